// File: rtl/tmp101_pkg.sv
// Shared definitions for the TMP101 temperature decoder path.
package tmp101_pkg;

  localparam int DigitW      = 4;
  localparam int RawW        = 12;
  localparam int DabbleIters = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LSB,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [DigitW-1:0] add3(
    input logic [DigitW-1:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin8_to_bcd_serial.sv
// Serial double-dabble: 8-bit binary to three BCD digits, one bit per cycle.
module bin8_to_bcd_serial
  import tmp101_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [7:0]            bin,
  output logic                  busy,
  output logic                  done,
  output logic [3*DigitW-1:0]   bcd
);

  logic [7:0]          bin_q;
  logic [3:0]          cnt;
  logic [3*DigitW-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      adj[i*DigitW +: DigitW] = add3(bcd[i*DigitW +: DigitW]);
    end
  end

  // done marks the cycle whose edge performs the final shift
  assign done = busy && (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      bin_q <= bin;
      bcd   <= '0;
      cnt   <= 4'(DabbleIters);
      busy  <= 1'b1;
    end else if (busy) begin
      {bcd, bin_q} <= {adj, bin_q} << 1;
      cnt          <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tmp101_temperature_decoder.sv
// TMP101 reading decoder: two bytes to sign + BCD digits.
// Optional hysteresis alarm enabled by defining TEMP_ALARM_EN.
module tmp101_temperature_decoder
  import tmp101_pkg::*;
#(
  parameter logic signed [7:0] AlarmHigh = 8'sd30,
  parameter logic signed [7:0] AlarmLow  = 8'sd28
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Restart,
  input  logic              ByteReady,
  input  logic [7:0]        ReceivedData,
  output logic [RawW-1:0]   TempRaw,
  output logic              Sign,
  output logic [DigitW-1:0] HundredsBCD,
  output logic [DigitW-1:0] TensBCD,
  output logic [DigitW-1:0] OnesBCD,
  output logic [DigitW-1:0] TenthsBCD,
  output logic              TempValid,
  output logic              Overrun,
  output logic              Alarm
);

  if (AlarmLow > AlarmHigh) begin : g_bad_thresholds
    $error("AlarmLow must not exceed AlarmHigh");
  end

  state_t state, next;

  logic [7:0]          msb_q;
  logic [3:0]          lsb_hi;
  logic [RawW-1:0]     raw_q;
  logic [DigitW-1:0]   tenths_q;
  logic [RawW-1:0]     raw_now;
  logic [RawW-1:0]     mag_now;
  logic [DigitW-1:0]   tenths_now;
  logic                load;
  logic                busy;
  logic                done;
  logic [3*DigitW-1:0] bcd;
  logic                converting;

  assign raw_now    = {msb_q, lsb_hi};
  assign mag_now    = raw_now[RawW-1] ? (~raw_now + 12'd1) : raw_now;
  assign tenths_now = 4'(({4'd0, mag_now[3:0]} * 8'd10) >> 4);
  assign converting = (state == LOAD) || (state == SHIFT)
                   || (state == DONE);

  bin8_to_bcd_serial u_bcd (
    .clk  (clock),
    .rst  (Reset),
    .load (load),
    .bin  (mag_now[11:4]),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    load = 1'b0;
    unique case (state)
      IDLE:     if (ByteReady) next = WAIT_LSB;
      WAIT_LSB: if (ByteReady) next = LOAD;
      LOAD: begin
        load = !Restart;
        next = SHIFT;
      end
      SHIFT: begin
        if (done)       next = DONE;
        else if (!busy) next = IDLE;
      end
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
    if (Restart) next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      msb_q       <= '0;
      lsb_hi      <= '0;
      raw_q       <= '0;
      tenths_q    <= '0;
      TempRaw     <= '0;
      Sign        <= 1'b0;
      HundredsBCD <= '0;
      TensBCD     <= '0;
      OnesBCD     <= '0;
      TenthsBCD   <= '0;
      TempValid   <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      TempValid <= 1'b0;
      if (Restart) begin
        Overrun <= 1'b0;
        msb_q   <= '0;
        lsb_hi  <= '0;
      end else begin
        if (ByteReady && converting) Overrun <= 1'b1;
        if (ByteReady && state == IDLE) msb_q <= ReceivedData;
        if (ByteReady && state == WAIT_LSB) begin
          lsb_hi <= ReceivedData[7:4];
        end
        if (state == LOAD) begin
          raw_q    <= raw_now;
          tenths_q <= tenths_now;
        end
        if (state == DONE) begin
          TempRaw     <= raw_q;
          Sign        <= raw_q[RawW-1];
          HundredsBCD <= bcd[11:8];
          TensBCD     <= bcd[7:4];
          OnesBCD     <= bcd[3:0];
          TenthsBCD   <= tenths_q;
          TempValid   <= 1'b1;
        end
      end
    end
  end

`ifdef TEMP_ALARM_EN
  logic signed [7:0] whole;
  assign whole = raw_q[11:4];

  // hysteresis: set at/above high, clear below low, else hold
  always_ff @(posedge clock) begin
    if (Reset) begin
      Alarm <= 1'b0;
    end else if (!Restart && state == DONE) begin
      if (whole >= AlarmHigh)     Alarm <= 1'b1;
      else if (whole < AlarmLow)  Alarm <= 1'b0;
    end
  end
`else
  assign Alarm = 1'b0;
`endif

endmodule

// File: doc/tmp101_temperature_decoder.md
# tmp101_temperature_decoder

Downstream consumer of the I2C data unit in the TMP101 temperature path. Collects the two bytes read back from the sensor's temperature register (MSB first, then LSB) and forms the 12-bit two's-complement reading. Converts it to sign, three BCD integer digits and one BCD tenths digit for the display stage. Raises a one-cycle valid strobe per completed reading.

## Interface
Parameters:
- AlarmHigh, 8'sd30, signed integer °C; alarm set threshold (used only with TEMP_ALARM_EN)
- AlarmLow, 8'sd28, signed integer °C; alarm clear threshold (used only with TEMP_ALARM_EN)

Ports:
- clock  input  1  system clock (60 MHz)
- Reset  input  1  synchronous, active-high reset
- Restart  input  1  pulse at start of each I2C read transaction; discards partial reading
- ByteReady  input  1  one-cycle strobe: ReceivedData holds a complete received byte
- ReceivedData  input  8  byte from I2C data unit
- TempRaw  output  12  last completed raw reading {MSB, LSB[7:4]}
- Sign  output  1  1 = negative reading
- HundredsBCD, TensBCD, OnesBCD, TenthsBCD  output  4 each  magnitude digits
- TempValid  output  1  one-cycle strobe: outputs just updated
- Overrun  output  1  sticky: byte arrived while converting
- Alarm  output  1  thermostat alarm

## Operation
- States: IDLE, WAIT_LSB, LOAD, SHIFT, DONE.
- IDLE: ByteReady → latch MSB, go WAIT_LSB.
- WAIT_LSB: ByteReady → latch LSB, go LOAD.
- LOAD: raw = {MSB, LSB[7:4]}. magnitude = raw[11] ? (~raw + 1) : raw, 12-bit unsigned. 0x800 yields 0x800 (128.0). Integer = magnitude[11:4] (0..128). Tenths = (magnitude[3:0] × 10) >> 4, truncating (0..9). Load integer into the serial BCD converter. Go SHIFT.
- SHIFT: exactly 8 double-dabble iterations, one per cycle, then go DONE.
- DONE: register TempRaw, Sign, the four digits and Alarm. Pulse TempValid. Go IDLE.
- LSB[3:0] is ignored.
- Sign = raw[11], including −0.0625 (shown as −000.0).
- ByteReady in LOAD, SHIFT or DONE: the byte is dropped and Overrun is set. Overrun clears only on Reset or Restart.
- Restart in any state: go to IDLE, discard latched bytes, clear Overrun. Output registers are kept.
- Restart coincident with ByteReady: Restart wins and the byte is dropped.
- Reset: state IDLE. TempRaw, Sign, all digits, TempValid, Overrun and Alarm all 0.

## Timing
- LSB sampled at edge E0 → LOAD in E0..E1 → SHIFT over edges E2..E9 → outputs updated and TempValid high for the single cycle following edge E10. Latency is 10 clocks from LSB sample.
- Outputs hold between TempValid strobes.
- Back-to-back readings need at least 11 clocks between the LSB and the next MSB. I2C byte spacing is several thousand clocks, so this is always met.
- No combinational input-to-output paths.

## Configuration
- TEMP_ALARM_EN defined: Alarm updates only in DONE, from signed integer raw[11:4] (floor).
  - Sets when raw[11:4] ≥ AlarmHigh.
  - Clears when raw[11:4] < AlarmLow.
  - Otherwise holds (hysteresis).
- TEMP_ALARM_EN undefined: Alarm port remains, tied 0. No comparator logic; parameters unused.

## Structure
- Shared package tmp101_pkg holds:
  - state encodings (IDLE..DONE)
  - BCD digit width (4)
  - raw width (12)
  - double-dabble iteration count (8)
- One sub-module, bin8_to_bcd_serial:
  - load/busy/done handshake
  - 8-bit binary in, 3 BCD digits out
  - add-3-if-≥5 then shift, one bit per cycle
- Top holds the FSM, byte latches, magnitude/tenths arithmetic, Overrun and alarm logic.

## Test plan
- Reset, then bytes 0x19, 0x00 → TempValid 10 clocks after LSB; TempRaw 0x190, Sign 0, digits 0,2,5,0.
- Bytes 0xE7, 0x00 → TempRaw 0xE70, Sign 1, digits 0,2,5,0. Bytes 0x80, 0x00 → Sign 1, digits 1,2,8,0.
- Bytes 0x7F, 0xF0 → 127.9 (digits 1,2,7,9). Bytes 0x00, 0x80 → 000.5. Bytes 0xFF, 0xF0 → Sign 1, 000.0.
- MSB 0x19, then Restart, then 0x20, 0x00 → a single TempValid showing 032.0; no reading built from 0x19.
- Third ByteReady during SHIFT → Overrun 1, reading unaffected; next Restart → Overrun 0.
- With TEMP_ALARM_EN and defaults:
  - readings 29, 30, 29, 27 → Alarm 0, 1, 1, 0.
  - Without the macro → Alarm always 0.
